// File: rtl/spi_slave_burst_pkg.sv
// Shared definitions for the burst SPI slave.
//   state_e      : controller states
//   MODE_CPOL/CPHA: bit positions inside the 2-bit mode word {CPOL,CPHA}
//   SYNC_STAGES  : depth of the pin synchronisers
//   PREP_CYCLES  : clk cycles between cs fall and the first bit on miso
package spi_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PREP  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    localparam int MODE_CPOL   = 1;
    localparam int MODE_CPHA   = 0;
    localparam int SYNC_STAGES = 3;
    localparam int PREP_CYCLES = 2;
endpackage

// File: rtl/spi_slave_burst_if.sv
// Word-level handshake between the SPI slave and the register/telemetry logic.
//   tx_data/tx_valid : next word to transmit, offered by the user (master side)
//   tx_req           : slave asks for the next word (1-cycle pulse)
//   rx_data/rx_valid : completed received frame (rx_valid is a 1-cycle pulse)
interface spi_slave_burst_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_req;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport slave  (input tx_data, tx_valid, output tx_req, rx_data, rx_valid);
    modport master (output tx_data, tx_valid, input tx_req, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_burst_sync.sv
// N-flop synchroniser for one asynchronous pin, with edge detection.
//   d_i    : asynchronous pin
//   q_o    : stage 2 (data sampling point)
//   lvl_o  : stage N (level aligned with the edge outputs)
//   rise_o : stage 2 high, stage N low
//   fall_o : stage 2 low, stage N high
module spi_sync_edge #(
    parameter int   N       = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [N-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= {N{RST_VAL}};
        else       sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o    = sync_q[N-2];
    assign lvl_o  = sync_q[N-1];
    assign rise_o =  sync_q[N-2] & ~sync_q[N-1];
    assign fall_o = ~sync_q[N-2] &  sync_q[N-1];
endmodule

// File: rtl/spi_slave_burst.sv
// Parametrised burst SPI slave: any CPOL/CPHA mode, configurable width and
// bit order, back-to-back frames per cs assertion, one-entry TX prefetch.
//   clk, reset        : system clock, synchronous active-high reset
//   sclk, mosi, cs    : asynchronous SPI pins (cs active low)
//   miso, miso_oe     : SPI data out and its tri-state enable
//   mode              : {CPOL,CPHA}, latched at cs fall
//   bus               : tx/rx word handshake
//   frame_cnt         : frames completed in the current cs assertion
//   underrun          : sticky, a TX_FILL word was loaded
//   busy              : controller not idle
module spi_slave_burst
    import spi_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter bit              LSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] TX_FILL = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        miso,
    output logic        miso_oe,
    input  logic [1:0]  mode,
    spi_slave_burst_if.slave bus,
    output logic [15:0] frame_cnt,
    output logic        underrun,
    output logic        busy
);
    localparam int CW = $clog2(DATA_W);

    logic cs_q2, cs_lvl, cs_rise, cs_fall;
    logic sclk_q2, sclk_q3, sclk_rise, sclk_fall;
    logic mosi_s, mosi_q3, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d_i(cs),
        .q_o(cs_q2), .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .d_i(sclk),
        .q_o(sclk_q2), .lvl_o(sclk_q3), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .d_i(mosi),
        .q_o(mosi_s), .lvl_o(mosi_q3), .rise_o(mosi_rise), .fall_o(mosi_fall));

    assign sync_unused = ^{cs_q2, sclk_q2, sclk_q3, mosi_q3, mosi_rise, mosi_fall};

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        prep_q, prep_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic              rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
    logic              hold_full_q, hold_full_d, pend_q, pend_d;
    logic              under_q, under_d;
    logic              skip_q, skip_d;   // CPHA=1: first shift edge only presents bit 0
    logic              load_q, load_d;   // frame done, next shift edge loads a new word
    logic [15:0]       frame_q, frame_d;

    logic              cpol, cpha, smp_edge, shf_edge, accept, load_fill;
    logic [DATA_W-1:0] load_word, tx_adv, rx_next;

    assign cpol     = mode_q[MODE_CPOL];
    assign cpha     = mode_q[MODE_CPHA];
    assign smp_edge = (cpol ^ cpha) ? sclk_fall : sclk_rise;
    assign shf_edge = (cpol ^ cpha) ? sclk_rise : sclk_fall;
    assign accept   = pend_q & bus.tx_valid;

    // A word accepted in the same cycle as the load bypasses the holding register.
    assign load_word = hold_full_q ? hold_q : (accept ? bus.tx_data : TX_FILL);
    assign load_fill = ~hold_full_q & ~accept;

    assign tx_adv  = LSB_FIRST ? {1'b0, tx_shift_q[DATA_W-1:1]} : {tx_shift_q[DATA_W-2:0], 1'b0};
    assign rx_next = LSB_FIRST ? {mosi_s, rx_shift_q[DATA_W-1:1]} : {rx_shift_q[DATA_W-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        prep_d      = prep_q;
        bit_d       = bit_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        pend_d      = pend_q;
        tx_req_d    = 1'b0;
        frame_d     = frame_q;
        under_d     = under_q;
        skip_d      = skip_q;
        load_d      = load_q;

        if (accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
            pend_d      = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    mode_d      = mode;
                    frame_d     = '0;
                    under_d     = 1'b0;
                    tx_req_d    = 1'b1;
                    pend_d      = 1'b1;
                    hold_full_d = 1'b0;
                    prep_d      = '0;
                    bit_d       = '0;
                    state_d     = ST_PREP;
                end
            end
            ST_PREP: begin
                if (prep_q == 2'(PREP_CYCLES - 1)) begin
                    tx_shift_d  = load_word;
                    under_d     = under_q | load_fill;
                    hold_full_d = 1'b0;
                    pend_d      = 1'b0;
                    skip_d      = cpha;
                    load_d      = 1'b0;
                    state_d     = ST_SHIFT;
                end else begin
                    prep_d = prep_q + 2'd1;
                end
            end
            ST_SHIFT: begin
                if (smp_edge) begin
                    rx_shift_d = rx_next;
                    if (bit_q == '0) begin
                        tx_req_d = 1'b1;
                        pend_d   = 1'b1;
                    end
                    if (bit_q == CW'(DATA_W - 1)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        frame_d    = frame_q + 16'd1;
                        bit_d      = '0;
                        load_d     = 1'b1;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end else if (shf_edge) begin
                    if (load_q) begin
                        tx_shift_d  = load_word;
                        under_d     = under_q | load_fill;
                        hold_full_d = 1'b0;
                        pend_d      = 1'b0;
                        load_d      = 1'b0;
                    end else if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_adv;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // cs rise overrides anything decided above for this cycle.
        if (cs_rise && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            rx_data_d   = rx_data_q;
            rx_valid_d  = 1'b0;
            frame_d     = frame_q;
            under_d     = under_q;
            tx_req_d    = 1'b0;
            pend_d      = 1'b0;
            hold_full_d = 1'b0;
            bit_d       = '0;
            skip_d      = 1'b0;
            load_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            prep_q      <= '0;
            bit_q       <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            pend_q      <= 1'b0;
            tx_req_q    <= 1'b0;
            frame_q     <= '0;
            under_q     <= 1'b0;
            skip_q      <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            prep_q      <= prep_d;
            bit_q       <= bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            pend_q      <= pend_d;
            tx_req_q    <= tx_req_d;
            frame_q     <= frame_d;
            under_q     <= under_d;
            skip_q      <= skip_d;
            load_q      <= load_d;
        end
    end

    assign miso         = cs_lvl ? 1'b0 : (LSB_FIRST ? tx_shift_q[0] : tx_shift_q[DATA_W-1]);
    assign miso_oe      = ~cs_lvl;
    assign bus.tx_req   = tx_req_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign frame_cnt    = frame_q;
    assign underrun     = under_q;
    assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_spi_slave_burst.sv
module tb_spi_slave_burst;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic reset, sclk, mosi, cs32, cs8;
    logic miso32, oe32, miso8, oe8, ur32, ur8, busy32, busy8;
    logic [1:0] mode32, mode8;
    logic [15:0] fc32, fc8;

    spi_slave_burst_if #(.DATA_W(32)) bus32();
    spi_slave_burst_if #(.DATA_W(8))  bus8();

    spi_slave_burst #(.DATA_W(32), .LSB_FIRST(1'b0), .TX_FILL(32'hDEAD_BEEF)) dut32 (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs32),
        .miso(miso32), .miso_oe(oe32), .mode(mode32), .bus(bus32),
        .frame_cnt(fc32), .underrun(ur32), .busy(busy32));
    spi_slave_burst #(.DATA_W(8), .LSB_FIRST(1'b1), .TX_FILL(8'h5A)) dut8 (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs8),
        .miso(miso8), .miso_oe(oe8), .mode(mode8), .bus(bus8),
        .frame_cnt(fc8), .underrun(ur8), .busy(busy8));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rxcnt32 = 0, rxcnt8 = 0, req32 = 0, req8 = 0, skip32 = -1;
    logic [31:0] exp32[$], tx_q32[$];
    logic [7:0]  exp8[$], tx_q8[$];
    logic [63:0] mosi_w[4], miso_w[4];
    logic [31:0] last_rx32;
    int rx0;

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: compare every rx_valid against the expected queue.
    task automatic mon32();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (bus32.rx_valid) begin
                checks++; rxcnt32++;
                if (exp32.size() == 0) begin
                    errors++; $display("FAIL rx32_unexpected: got rx_valid data=%h, required no rx_valid", bus32.rx_data);
                end else begin
                    e = exp32.pop_front();
                    if (bus32.rx_data !== e) begin
                        errors++; $display("FAIL rx32_data: got %h, required %h", bus32.rx_data, e);
                    end
                end
            end
        end
    endtask

    task automatic mon8();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus8.rx_valid) begin
                checks++; rxcnt8++;
                if (exp8.size() == 0) begin
                    errors++; $display("FAIL rx8_unexpected: got rx_valid data=%h, required no rx_valid", bus8.rx_data);
                end else begin
                    e = exp8.pop_front();
                    if (bus8.rx_data !== e) begin
                        errors++; $display("FAIL rx8_data: got %h, required %h", bus8.rx_data, e);
                    end
                end
            end
        end
    endtask

    // User side: answer each tx_req with the next queued word (dummy 0 once empty).
    task automatic resp32();
        logic [31:0] w;
        bit give;
        forever begin
            @(negedge clk);
            if (cs32) req32 = 0;
            if (bus32.tx_req) begin
                give = (req32 != skip32);
                w = (tx_q32.size() > 0) ? tx_q32.pop_front() : 32'h0;
                req32++;
                if (give) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    bus32.tx_data = w; bus32.tx_valid = 1'b1;
                    @(negedge clk);
                    bus32.tx_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic resp8();
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (cs8) req8 = 0;
            if (bus8.tx_req) begin
                w = (tx_q8.size() > 0) ? tx_q8.pop_front() : 8'h0;
                req8++;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                bus8.tx_data = w; bus8.tx_valid = 1'b1;
                @(negedge clk);
                bus8.tx_valid = 1'b0;
            end
        end
    endtask

    // SPI master: nfr frames from mosi_w, miso collected into miso_w.
    // abort_bits != 0 clocks only that many bits of frame 0 then raises cs.
    task automatic spi_xfer(input bit s8, input logic [1:0] m, input int nfr, input int abort_bits);
        int n, b;
        bit cpol, cpha;
        n = s8 ? 8 : 32; cpol = m[1]; cpha = m[0];
        sclk = cpol;
        if (s8) mode8 = m; else mode32 = m;
        wclk(6);
        if (s8) cs8 = 1'b0; else cs32 = 1'b0;
        wclk(8);
        for (int f = 0; f < nfr; f++) begin
            miso_w[f] = '0;
            if (abort_bits == 0) begin
                if (s8) exp8.push_back(mosi_w[f][7:0]); else exp32.push_back(mosi_w[f][31:0]);
            end
            for (int i = 0; i < n; i++) begin
                if (abort_bits != 0 && i == abort_bits) break;
                b = s8 ? i : n - 1 - i;
                if (!cpha) begin
                    mosi = mosi_w[f][b];
                    wclk(HALF);
                    sclk = ~cpol; miso_w[f][b] = s8 ? miso8 : miso32;
                    wclk(HALF);
                    sclk = cpol;
                end else begin
                    sclk = ~cpol; mosi = mosi_w[f][b];
                    wclk(HALF);
                    sclk = cpol; miso_w[f][b] = s8 ? miso8 : miso32;
                    wclk(HALF);
                end
            end
        end
        wclk(HALF);
        if (s8) cs8 = 1'b1; else cs32 = 1'b1;
        wclk(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; cs32 = 1'b1; cs8 = 1'b1; sclk = 1'b0; mosi = 1'b0;
        mode32 = 2'd0; mode8 = 2'd0;
        bus32.tx_valid = 1'b0; bus32.tx_data = '0; bus8.tx_valid = 1'b0; bus8.tx_data = '0;
        wclk(4);
        reset = 1'b0;
        wclk(2);
        checks++; if (miso32 !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b, required 0", miso32); end
        checks++; if (oe32 !== 1'b0) begin errors++; $display("FAIL rst_miso_oe: got %b, required 0", oe32); end
        checks++; if (bus32.tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req: got %b, required 0", bus32.tx_req); end
        checks++; if (bus32.rx_data !== 32'h0) begin errors++; $display("FAIL rst_rx_data: got %h, required 0", bus32.rx_data); end
        checks++; if (bus32.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b, required 0", bus32.rx_valid); end
        checks++; if (fc32 !== 16'h0) begin errors++; $display("FAIL rst_frame_cnt: got %0d, required 0", fc32); end
        checks++; if (ur32 !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b, required 0", ur32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy32); end
        checks++;
        if ({miso8, oe8, bus8.tx_req, bus8.rx_valid, ur8, busy8, fc8, bus8.rx_data} !== 30'h0) begin
            errors++; $display("FAIL rst_dut8: got %h, required 0",
                               {miso8, oe8, bus8.tx_req, bus8.rx_valid, ur8, busy8, fc8, bus8.rx_data});
        end
    endtask

    task automatic test_mode0_single();
        rx0 = rxcnt32;
        tx_q32.push_back(32'hA5A5_0F0F);
        mosi_w[0] = 64'h1234_5678;
        spi_xfer(1'b0, 2'd0, 1, 0);
        checks++; if (miso_w[0][31:0] !== 32'hA5A5_0F0F) begin errors++; $display("FAIL m0_miso: got %h, required a5a50f0f", miso_w[0][31:0]); end
        checks++; if (bus32.rx_data !== 32'h1234_5678) begin errors++; $display("FAIL m0_rx_data: got %h, required 12345678", bus32.rx_data); end
        checks++; if (rxcnt32 - rx0 != 1) begin errors++; $display("FAIL m0_rx_pulses: got %0d, required 1", rxcnt32 - rx0); end
        checks++; if (fc32 !== 16'd1) begin errors++; $display("FAIL m0_frame_cnt: got %0d, required 1", fc32); end
        checks++; if (ur32 !== 1'b0) begin errors++; $display("FAIL m0_underrun: got %b, required 0", ur32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL m0_busy: got %b, required 0", busy32); end
    endtask

    task automatic test_modes8();
        for (int m = 0; m < 4; m++) begin
            tx_q8.push_back(8'hC3);
            mosi_w[0] = 64'h3C;
            spi_xfer(1'b1, 2'(m), 1, 0);
            checks++; if (miso_w[0][7:0] !== 8'hC3) begin errors++; $display("FAIL mode%0d_miso: got %h, required c3", m, miso_w[0][7:0]); end
            checks++; if (ur8 !== 1'b0) begin errors++; $display("FAIL mode%0d_underrun: got %b, required 0", m, ur8); end
            checks++; if (fc8 !== 16'd1) begin errors++; $display("FAIL mode%0d_frame_cnt: got %0d, required 1", m, fc8); end
            checks++; if (exp8.size() != 0) begin errors++; $display("FAIL mode%0d_rx_missing: got %0d pending, required 0", m, exp8.size()); end
        end
    endtask

    task automatic test_burst();
        logic [31:0] tw[3];
        tw[0] = 32'h0123_4567; tw[1] = 32'h89AB_CDEF; tw[2] = 32'hFEDC_BA98;
        rx0 = rxcnt32;
        for (int f = 0; f < 3; f++) begin
            tx_q32.push_back(tw[f]);
            mosi_w[f] = {32'h0, $urandom()};
        end
        spi_xfer(1'b0, 2'd3, 3, 0);
        for (int f = 0; f < 3; f++) begin
            checks++; if (miso_w[f][31:0] !== tw[f]) begin errors++; $display("FAIL burst_miso%0d: got %h, required %h", f, miso_w[f][31:0], tw[f]); end
        end
        checks++; if (rxcnt32 - rx0 != 3) begin errors++; $display("FAIL burst_rx_pulses: got %0d, required 3", rxcnt32 - rx0); end
        checks++; if (fc32 !== 16'd3) begin errors++; $display("FAIL burst_frame_cnt: got %0d, required 3", fc32); end
        checks++; if (ur32 !== 1'b0) begin errors++; $display("FAIL burst_underrun: got %b, required 0", ur32); end
    endtask

    task automatic test_underrun();
        logic [31:0] req[3];
        req[0] = 32'h1111_AAAA; req[1] = 32'h2222_BBBB; req[2] = 32'h3333_CCCC;
        skip32 = 1;
        for (int f = 0; f < 3; f++) begin
            tx_q32.push_back(req[f]);
            mosi_w[f] = {32'h0, $urandom()};
        end
        spi_xfer(1'b0, 2'd1, 3, 0);
        skip32 = -1;
        last_rx32 = mosi_w[2][31:0];
        checks++; if (miso_w[0][31:0] !== req[0]) begin errors++; $display("FAIL ur_miso0: got %h, required %h", miso_w[0][31:0], req[0]); end
        checks++; if (miso_w[1][31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ur_miso1: got %h, required deadbeef", miso_w[1][31:0]); end
        checks++; if (miso_w[2][31:0] !== req[2]) begin errors++; $display("FAIL ur_miso2: got %h, required %h", miso_w[2][31:0], req[2]); end
        checks++; if (ur32 !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b, required 1", ur32); end
        checks++; if (fc32 !== 16'd3) begin errors++; $display("FAIL ur_frame_cnt: got %0d, required 3", fc32); end
    endtask

    task automatic test_abort();
        rx0 = rxcnt32;
        tx_q32.push_back(32'h7777_8888);
        mosi_w[0] = 64'hCAFE_F00D;
        spi_xfer(1'b0, 2'd0, 1, 13);
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy32); end
        wclk(4);
        checks++; if (rxcnt32 != rx0) begin errors++; $display("FAIL abort_rx_pulses: got %0d, required 0", rxcnt32 - rx0); end
        checks++; if (bus32.rx_data !== last_rx32) begin errors++; $display("FAIL abort_rx_hold: got %h, required %h", bus32.rx_data, last_rx32); end
        checks++; if (fc32 !== 16'd0) begin errors++; $display("FAIL abort_frame_cnt: got %0d, required 0", fc32); end
        checks++; if (ur32 !== 1'b0) begin errors++; $display("FAIL abort_ur_cleared: got %b, required 0", ur32); end
        tx_q32.push_back(32'h5555_6666);
        mosi_w[0] = 64'h0BAD_BEEF;
        spi_xfer(1'b0, 2'd0, 1, 0);
        checks++; if (miso_w[0][31:0] !== 32'h5555_6666) begin errors++; $display("FAIL abort_next_miso: got %h, required 55556666", miso_w[0][31:0]); end
        checks++; if (bus32.rx_data !== 32'h0BAD_BEEF) begin errors++; $display("FAIL abort_next_rx: got %h, required 0badbeef", bus32.rx_data); end
    endtask

    task automatic test_reset_mid();
        tx_q32.push_back(32'h1111_2222);
        mode32 = 2'd0; sclk = 1'b0;
        wclk(6);
        cs32 = 1'b0;
        wclk(8);
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            wclk(HALF); sclk = 1'b1;
            wclk(HALF); sclk = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (miso32 !== 1'b0) begin errors++; $display("FAIL rmid_miso: got %b, required 0", miso32); end
        checks++; if (oe32 !== 1'b0) begin errors++; $display("FAIL rmid_miso_oe: got %b, required 0", oe32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy32); end
        checks++; if (bus32.rx_data !== 32'h0) begin errors++; $display("FAIL rmid_rx_data: got %h, required 0", bus32.rx_data); end
        checks++; if (fc32 !== 16'h0) begin errors++; $display("FAIL rmid_frame_cnt: got %0d, required 0", fc32); end
        checks++;
        if ({bus32.tx_req, bus32.rx_valid, ur32} !== 3'b000) begin
            errors++; $display("FAIL rmid_flags: got %b, required 000", {bus32.tx_req, bus32.rx_valid, ur32});
        end
        cs32 = 1'b1;
        wclk(4);
        reset = 1'b0;
        wclk(4);
        tx_q32.delete();
        tx_q32.push_back(32'h9ABC_DEF0);
        mosi_w[0] = 64'h2468_ACE1;
        spi_xfer(1'b0, 2'd2, 1, 0);
        checks++; if (miso_w[0][31:0] !== 32'h9ABC_DEF0) begin errors++; $display("FAIL rmid_next_miso: got %h, required 9abcdef0", miso_w[0][31:0]); end
        checks++; if (bus32.rx_data !== 32'h2468_ACE1) begin errors++; $display("FAIL rmid_next_rx: got %h, required 2468ace1", bus32.rx_data); end
        checks++; if (fc32 !== 16'd1) begin errors++; $display("FAIL rmid_next_fc: got %0d, required 1", fc32); end
    endtask

    initial begin
        fork
            mon32();
            mon8();
            resp32();
            resp8();
        join_none
        test_reset();
        test_mode0_single();
        test_modes8();
        test_burst();
        test_underrun();
        test_abort();
        test_reset_mid();
        wclk(10);
        checks++;
        if (exp32.size() != 0 || exp8.size() != 0) begin
            errors++; $display("FAIL rx_missing_end: got %0d/%0d pending, required 0/0", exp32.size(), exp8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
